// File: rtl/command_decapsulate_inex_if.sv
// Bundle for the decapsulator's tagged-response input and its four
// destination output channels (valid/ready), plus status outputs.
interface command_decapsulate_inex_if #(
  parameter int CNT_W = 16
);
  logic [65:0]      iv_command;
  logic             i_command_wr;

  logic [63:0]      ov_command_to_int;
  logic             o_valid_to_int;
  logic             i_ready_from_int;

  logic [63:0]      ov_command_to_ext_1;
  logic             o_valid_to_ext_1;
  logic             i_ready_from_ext_1;

  logic [63:0]      ov_command_to_ext_2;
  logic             o_valid_to_ext_2;
  logic             i_ready_from_ext_2;

  logic [63:0]      ov_command_to_ext_3;
  logic             o_valid_to_ext_3;
  logic             i_ready_from_ext_3;

  logic [3:0]       ov_full;
  logic [CNT_W-1:0] ov_drop_cnt;

  // Producer/consumer side: drives responses in, readies, observes outputs.
  modport master (
    output iv_command, i_command_wr,
    output i_ready_from_int, i_ready_from_ext_1, i_ready_from_ext_2, i_ready_from_ext_3,
    input  ov_command_to_int, o_valid_to_int,
    input  ov_command_to_ext_1, o_valid_to_ext_1,
    input  ov_command_to_ext_2, o_valid_to_ext_2,
    input  ov_command_to_ext_3, o_valid_to_ext_3,
    input  ov_full, ov_drop_cnt
  );

  // Decapsulator side.
  modport slave (
    input  iv_command, i_command_wr,
    input  i_ready_from_int, i_ready_from_ext_1, i_ready_from_ext_2, i_ready_from_ext_3,
    output ov_command_to_int, o_valid_to_int,
    output ov_command_to_ext_1, o_valid_to_ext_1,
    output ov_command_to_ext_2, o_valid_to_ext_2,
    output ov_command_to_ext_3, o_valid_to_ext_3,
    output ov_full, ov_drop_cnt
  );
endinterface

// File: rtl/command_decapsulate_inex.sv
// Return path of the local access controller: strips the 2-bit source tag
// from a 66-bit response and steers the restored 64-bit word into one of
// four FWFT FIFOs (interior, ext1..ext3). Pushes into a full FIFO with no
// simultaneous pop are dropped and counted in a saturating counter.
module command_decapsulate_inex #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  command_decapsulate_inex_if.slave   bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int NDST   = 4;

  typedef enum logic [1:0] {
    DST_INT  = 2'b00,
    DST_EXT1 = 2'b01,
    DST_EXT2 = 2'b10,
    DST_EXT3 = 2'b11
  } dst_e;

  logic [PTR_W-1:0]  wr_ptr_q [NDST];
  logic [PTR_W-1:0]  wr_ptr_d [NDST];
  logic [PTR_W-1:0]  rd_ptr_q [NDST];
  logic [PTR_W-1:0]  rd_ptr_d [NDST];
  logic [FILL_W-1:0] count_q  [NDST];
  logic [FILL_W-1:0] count_d  [NDST];
  logic [63:0]       mem_q    [NDST][DEPTH];
  logic [63:0]       mem_d    [NDST][DEPTH];
  logic [NDST-1:0]   full_q, full_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  dst_e              tag;
  logic [63:0]       payload;
  logic [NDST-1:0]   ready;
  logic [NDST-1:0]   valid;
  logic [NDST-1:0]   pop;
  logic [NDST-1:0]   push_req;
  logic [NDST-1:0]   accept;
  logic              drop;
  logic [63:0]       head [NDST];

  // Decode tag and restore the original 64-bit word; gather readies.
  always_comb begin
    tag     = dst_e'(bus.iv_command[63:62]);
    payload = {bus.iv_command[65:64], bus.iv_command[61:0]};
    ready   = {bus.i_ready_from_ext_3, bus.i_ready_from_ext_2,
               bus.i_ready_from_ext_1, bus.i_ready_from_int};
  end

  // Per-destination push/pop bookkeeping and drop counting.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
    full_d     = '0;
    valid      = '0;
    pop        = '0;
    push_req   = '0;
    accept     = '0;
    drop       = 1'b0;
    drop_cnt_d = drop_cnt_q;
    for (int unsigned k = 0; k < NDST; k++) begin
      valid[k]    = (count_q[k] != '0);
      pop[k]      = valid[k] & ready[k];
      push_req[k] = bus.i_command_wr && (tag == dst_e'(k));
      // A pop in the same cycle frees a slot, so a full FIFO still accepts.
      accept[k]   = push_req[k] && ((count_q[k] != FILL_W'(DEPTH)) || pop[k]);
      if (accept[k]) begin
        mem_d[k][wr_ptr_q[k]] = payload;
        wr_ptr_d[k]           = wr_ptr_q[k] + PTR_W'(1);
      end
      if (pop[k]) begin
        rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(1);
      end
      case ({accept[k], pop[k]})
        2'b10:   count_d[k] = count_q[k] + FILL_W'(1);
        2'b01:   count_d[k] = count_q[k] - FILL_W'(1);
        default: count_d[k] = count_q[k];
      endcase
      if (push_req[k] && !accept[k]) begin
        drop = 1'b1;
      end
      full_d[k] = (count_d[k] == FILL_W'(DEPTH));
    end
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  // Control state: pointers, fill counts, full flags, drop counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < NDST; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        count_q[k]  <= '0;
      end
      full_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage array; contents are don't-care while a FIFO is empty.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  // Head words, forced to zero when the FIFO holds nothing.
  always_comb begin
    for (int unsigned k = 0; k < NDST; k++) begin
      head[k] = (count_q[k] != '0) ? mem_q[k][rd_ptr_q[k]] : '0;
    end
  end

  assign bus.ov_command_to_int   = head[DST_INT];
  assign bus.o_valid_to_int      = (count_q[DST_INT]  != '0);
  assign bus.ov_command_to_ext_1 = head[DST_EXT1];
  assign bus.o_valid_to_ext_1    = (count_q[DST_EXT1] != '0);
  assign bus.ov_command_to_ext_2 = head[DST_EXT2];
  assign bus.o_valid_to_ext_2    = (count_q[DST_EXT2] != '0);
  assign bus.ov_command_to_ext_3 = head[DST_EXT3];
  assign bus.o_valid_to_ext_3    = (count_q[DST_EXT3] != '0);
  assign bus.ov_full             = full_q;
  assign bus.ov_drop_cnt         = drop_cnt_q;

endmodule
